// File: rtl/conv111_pkg.sv
// Shared constants and FSM encoding for the rate-1/2 convolutional encoder.
// Generators live here so the encoder and the decoder's expected-symbol logic agree.
package conv111_pkg;

    localparam int         CONV_K  = 3;
    localparam logic [2:0] CONV_G0 = 3'b111;
    localparam logic [2:0] CONV_G1 = 3'b101;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } enc_state_t;

endpackage

// File: rtl/conv_parity111.sv
// Combinational parity pair for window {u, s[0], ..., s[K-2]} against two generators.
// Shared with the decoder so its expected symbols match the encoder bit for bit.
module conv_parity111 #(
    parameter int K = 3
) (
    input  logic         u,
    input  logic [K-2:0] s,
    input  logic [K-1:0] g0,
    input  logic [K-1:0] g1,
    output logic [1:0]   pair
);

    logic [K-1:0] w;

    // Newest bit u sits in the MSB, the oldest state bit in the LSB.
    always_comb begin
        w[K-1] = u;
        for (int i = 0; i < K - 1; i++) begin
            w[K-2-i] = s[i];
        end
    end

    assign pair = {^(w & g1), ^(w & g0)};

endmodule

// File: rtl/conv_enc111.sv
// Rate-1/2 convolutional encoder with registered valid/ready symbol output.
// Define CONV_ENC111_TAIL_EN to append K-1 zero tail bits after each frame.
module conv_enc111
    import conv111_pkg::*;
#(
    parameter int           K  = CONV_K,
    parameter logic [K-1:0] G0 = K'(CONV_G0),
    parameter logic [K-1:0] G1 = K'(CONV_G1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last
);

    logic [K-2:0] s;
    logic [K-2:0] s_next;
    logic         u;
    logic         out_free;
    logic         load;
    logic [1:0]   pair;

    assign out_free = !out_valid || out_ready;

`ifdef CONV_ENC111_TAIL_EN
    localparam int TW = $clog2(K);

    enc_state_t    state;
    logic [TW-1:0] tail_cnt;

    assign in_ready = (state == S_RUN) && out_free;
    // Tail symbols are driven by a zero input regardless of in_bit.
    assign u        = (state == S_FLUSH) ? 1'b0 : in_bit;
    assign load     = (state == S_FLUSH) ? out_free : (in_valid && in_ready);
`else
    assign in_ready = out_free;
    assign u        = in_bit;
    assign load     = in_valid && in_ready;
`endif

    assign s_next = {s[K-3:0], u};

    conv_parity111 #(.K(K)) u_parity (
        .u    (u),
        .s    (s),
        .g0   (G0),
        .g1   (G1),
        .pair (pair)
    );

`ifdef CONV_ENC111_TAIL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            tail_cnt  <= '0;
            s         <= '0;
            out_valid <= 1'b0;
            out_pair  <= 2'b00;
            out_last  <= 1'b0;
        end else begin
            if (load) begin
                out_pair  <= pair;
                out_valid <= 1'b1;
                s         <= s_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                S_RUN: begin
                    if (load) begin
                        out_last <= 1'b0;
                        if (in_last) begin
                            state    <= S_FLUSH;
                            tail_cnt <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (load) begin
                        tail_cnt <= tail_cnt + 1'b1;
                        // Final tail symbol: the state register has shifted back to zero.
                        if (tail_cnt == TW'(K - 2)) begin
                            out_last <= 1'b1;
                            state    <= S_RUN;
                        end else begin
                            out_last <= 1'b0;
                        end
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            out_valid <= 1'b0;
            out_pair  <= 2'b00;
            out_last  <= 1'b0;
        end else begin
            if (load) begin
                out_pair  <= pair;
                out_valid <= 1'b1;
                out_last  <= in_last;
                // Without a tail, the next frame is forced to start from state 0.
                s         <= in_last ? '0 : s_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_enc111.sv
// Directed bench for conv_enc111; expected symbols follow CONV_ENC111_TAIL_EN.
module tb_conv_enc111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_pair;
    logic       out_last;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [2:0] q[$];
    int         cq[$];

    conv_enc111 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each entry is {out_last, out_pair} of a completed transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q.push_back({out_last, out_pair});
            cq.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        q.delete();
        cq.delete();
    endtask

    task automatic send_frame(input logic [7:0] bits, input int n, input logic last_on_end);
        for (int i = 0; i < n; i++) begin
            int  waited;
            logic acc;
            waited = 0;
            in_valid = 1'b1;
            in_bit   = bits[i];
            in_last  = last_on_end && (i == n - 1);
            do begin
                #1;
                acc = in_ready;
                step();
                waited++;
            end while (!acc && waited < 50);
            if (!acc) begin
                failures++;
                $display("FAIL send_timeout bit=%0d in_ready stuck at 0", i);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_syms(input int n);
        int budget;
        budget = 0;
        while (q.size() < n && budget < 40) begin
            step();
            budget++;
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_pair !== 2'b00) begin failures++; $display("FAIL reset_out_pair got=%b want=00", out_pair); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        step();
    endtask

    // Frame 1,0,1,1 at full rate.
    task automatic test_frame();
        logic [2:0] exp[$];
`ifdef CONV_ENC111_TAIL_EN
        exp = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b111};
`else
        exp = '{3'b011, 3'b001, 3'b000, 3'b110};
`endif
        do_reset();
        out_ready = 1'b1;
        send_frame(8'b0000_1101, 4, 1'b1);
        wait_syms(exp.size());
        checks++;
        if (q.size() != exp.size()) begin
            failures++; $display("FAIL frame_count got=%0d want=%0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (q[i] !== exp[i]) begin failures++; $display("FAIL frame_sym%0d got=%b want=%b", i, q[i], exp[i]); end
                checks++;
                if (cq[i] != cq[0] + i) begin failures++; $display("FAIL frame_rate%0d got_cycle=%0d want_cycle=%0d", i, cq[i], cq[0] + i); end
            end
        end
    endtask

    // Same frame, with out_ready dropped for 3 cycles while symbol 2 is presented.
    task automatic test_backpressure();
        logic [2:0] exp[$];
`ifdef CONV_ENC111_TAIL_EN
        exp = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b111};
`else
        exp = '{3'b011, 3'b001, 3'b000, 3'b110};
`endif
        do_reset();
        out_ready = 1'b1;
        fork
            send_frame(8'b0000_1101, 4, 1'b1);
            begin
                int n;
                n = 0;
                do begin step(); n++; end while (q.size() < 1 && n < 50);
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++; if (out_pair !== 2'b01 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold%0d got=%b/%b want=01/1", k, out_pair, out_valid); end
                    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b want=0", k, in_ready); end
                    step();
                end
                out_ready = 1'b1;
            end
        join
        wait_syms(exp.size());
        checks++;
        if (q.size() != exp.size()) begin
            failures++; $display("FAIL bp_count got=%0d want=%0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (q[i] !== exp[i]) begin failures++; $display("FAIL bp_sym%0d got=%b want=%b", i, q[i], exp[i]); end
            end
        end
    endtask

    // Single-bit frame, then a new frame must start from state 0.
    task automatic test_single();
        logic [2:0] exp[$];
`ifdef CONV_ENC111_TAIL_EN
        exp = '{3'b011, 3'b001, 3'b111};
`else
        exp = '{3'b111};
`endif
        do_reset();
        out_ready = 1'b1;
        send_frame(8'b0000_0001, 1, 1'b1);
        wait_syms(exp.size());
        checks++;
        if (q.size() != exp.size()) begin
            failures++; $display("FAIL single_count got=%0d want=%0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (q[i] !== exp[i]) begin failures++; $display("FAIL single_sym%0d got=%b want=%b", i, q[i], exp[i]); end
            end
        end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
        q.delete();
        send_frame(8'b0000_0001, 1, 1'b0);
        wait_syms(1);
        checks++;
        if (q.size() < 1 || q[0][1:0] !== 2'b11) begin
            failures++; $display("FAIL single_next_first got=%b want=11 (count=%0d)", (q.size() > 0) ? q[0][1:0] : 2'bxx, q.size());
        end
    endtask

    // Abort a frame with reset after two bits; the next frame starts clean.
    task automatic test_reset_mid();
        logic [2:0] exp[$];
`ifdef CONV_ENC111_TAIL_EN
        exp = '{3'b011, 3'b001, 3'b111};
`else
        exp = '{3'b111};
`endif
        do_reset();
        out_ready = 1'b1;
        send_frame(8'b0000_0011, 2, 1'b0);
        do_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL mid_reset_clear got=%b/%b want=0/0", out_valid, out_last); end
        step();
        send_frame(8'b0000_0001, 1, 1'b1);
        wait_syms(exp.size());
        checks++;
        if (q.size() != exp.size()) begin
            failures++; $display("FAIL mid_count got=%0d want=%0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (q[i] !== exp[i]) begin failures++; $display("FAIL mid_sym%0d got=%b want=%b", i, q[i], exp[i]); end
            end
        end
    endtask

    // Frame 1,1 then next bit 1.
    task automatic test_two_bit();
        logic [2:0] exp[$];
`ifdef CONV_ENC111_TAIL_EN
        exp = '{3'b011, 3'b010, 3'b010, 3'b111};
`else
        exp = '{3'b011, 3'b110};
`endif
        do_reset();
        out_ready = 1'b1;
        send_frame(8'b0000_0011, 2, 1'b1);
        wait_syms(exp.size());
        checks++;
        if (q.size() != exp.size()) begin
            failures++; $display("FAIL two_count got=%0d want=%0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (q[i] !== exp[i]) begin failures++; $display("FAIL two_sym%0d got=%b want=%b", i, q[i], exp[i]); end
            end
        end
        q.delete();
        send_frame(8'b0000_0001, 1, 1'b0);
        wait_syms(1);
        checks++;
        if (q.size() != 1 || q[0] !== 3'b011) begin
            failures++; $display("FAIL two_next got=%b want=011 (count=%0d)", (q.size() > 0) ? q[0] : 3'bxxx, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_single();
        test_reset_mid();
        test_two_bit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_enc111.md
# conv_enc111

Rate-1/2 convolutional encoder: the transmit end of the Viterbi link, producing the 2-bit code symbols that the decoder's branch-metric, add-compare-select and traceback stages consume. It accepts one information bit per handshake, shifts it through a (K-1)-bit state register and emits one parity pair per bit through a registered valid/ready output. At end of frame it optionally appends K-1 zero tail bits, returning the trellis to state 0 so decoder traceback starts from a known state.

## Interface
- `K`, 3, constraint length; the state register is K-1 bits wide
- `G0`, 3'b111, generator for `out_pair[0]`, K bits wide
- `G1`, 3'b101, generator for `out_pair[1]`, K bits wide

- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_bit` and `in_last` are valid
- `in_ready`  out  1  encoder accepts an input this cycle
- `in_bit`  in  1  information bit
- `in_last`  in  1  marks the final information bit of a frame
- `out_valid`  out  1  `out_pair` holds a symbol
- `out_ready`  in  1  downstream accepts the symbol
- `out_pair`  out  2  {parity G1, parity G0}
- `out_last`  out  1  marks the final symbol of a frame

## Operation
- Encoder state `s[K-2:0]`: `s[0]` holds the most recent bit. Window `w = {u, s[0], …, s[K-2]}` (u is the MSB). `p_i = ^(w & G_i)`. After each symbol, `s <= {s[K-3:0], u}`.
- States: `S_RUN` and `S_FLUSH`; reset state is `S_RUN`.
- `S_RUN`:
  - `in_ready = !out_valid || out_ready`.
  - On accept (`in_valid && in_ready`): load `out_pair`, set `out_valid`, shift the state.
  - If `in_last` is set, go to `S_FLUSH`, clear the tail counter, and drive `out_last = 0` (tail enabled).
- `S_FLUSH`:
  - `in_ready = 0`.
  - Each cycle with `!out_valid || out_ready`, encode `u = 0` and increment the tail counter.
  - On tail symbol K-1: set `out_last = 1` and return to `S_RUN`. The state register is then all zero.
- Output register holds its value while `out_valid && !out_ready`. Back-to-back transfers run at full rate.
- `out_valid` clears only when `out_ready` is high and no new symbol is loaded.
- Reset mid-frame: the frame is abandoned. The state register, tail counter, `out_valid` and `out_last` clear. The FSM returns to `S_RUN`.
- Reset values:
  - `out_valid = 0`, `out_pair = 2'b00`, `out_last = 0`.
  - `in_ready = 1` (combinational from `out_valid = 0`, `S_RUN`).
- A frame of length 1 (`in_last` on the first bit) is legal and produces 1 + (K-1) symbols.
- `in_valid` while `in_ready = 0` is ignored. The source holds its data.

## Timing
- Latency: the symbol for an accepted bit appears registered on the next cycle.
- Throughput: one symbol per cycle when `out_ready` is held high.
- Tail: K-1 consecutive cycles after the last data symbol's load, extended by any backpressure.
- The first bit of the next frame is accepted on the cycle after the final tail symbol is loaded, if the output is free.

## Configuration
- Macro: `CONV_ENC111_TAIL_EN`.
- Defined:
  - Zero-tail termination as described above.
  - A frame emits N + K - 1 symbols.
  - `out_last` is on the last tail symbol.
- Undefined:
  - `S_FLUSH` and the tail counter are compiled out, and the encoder never leaves `S_RUN`.
  - `out_last` is asserted with the symbol of the `in_last` bit.
  - The state register clears to zero on that accept, so the next frame still starts from state 0.
  - A frame emits N symbols.

## Structure
- Package `conv111_pkg`:
  - FSM state enum `enc_state_t` {`S_RUN`, `S_FLUSH`}.
  - Default constants `CONV_K`, `CONV_G0`, `CONV_G1`, shared with the decoder so generators stay consistent.
- Sub-module `conv_parity111`: combinational; inputs u, s and the generators; outputs the 2-bit pair. It is reused by the decoder's expected-symbol logic.

## Test plan
- Reset and idle: after reset → `out_valid = 0`, `out_pair = 00`, `out_last = 0`, `in_ready = 1`.
- Frame 1,0,1,1 (last on 4th), `out_ready` = 1, tail enabled → symbols 11, 01, 00, 10, 10, 11 on consecutive cycles; `out_last` only on the 6th.
- Same frame, `out_ready` low for 3 cycles during symbol 2:
  - `out_pair` = 01 is held stable.
  - `in_ready = 0`.
  - No bit is lost and the sequence is unchanged.
- Single-bit frame `in_bit` = 1 with `in_last` → 11, 01, 11; then `in_ready` returns; the next frame starting with 1 yields 11 (state is zero).
- Reset asserted after 2 data bits, then frame 1 → first symbol 11, and no `out_last` from the aborted frame.
- Macro undefined, frame 1,1 with last → 11, 10; `out_last` on the 2nd; the next bit 1 gives 11.
